csa16_ins: RTL and testbench



---
 rtl/csa16_pkg.sv | 16 +
 rtl/csa16_rca4.sv | 19 +
 rtl/csa16_ins.sv | 89 ++++++++
 tb/tb_csa16_ins.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/csa16_pkg.sv
// rtl/csa16_pkg.sv - shared widths, types and full-adder helper for the csa16 carry-select adder
package csa16_pkg;

    localparam int CSA_W   = 16;
    localparam int BLK_W   = 4;
    localparam int NUM_BLK = CSA_W / BLK_W;

    typedef logic [CSA_W-1:0] csa_word_t;
    typedef logic [BLK_W-1:0] csa_blk_t;

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
        fa = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/csa16_rca4.sv
// rtl/csa16_rca4.sv - 4-bit ripple-carry adder built from per-bit full adders
module csa16_rca4
    import csa16_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic c1, c2, c3;

    assign {c1, s[0]} = fa(a[0], b[0], ci);
    assign {c2, s[1]} = fa(a[1], b[1], c1);
    assign {c3, s[2]} = fa(a[2], b[2], c2);
    assign {co, s[3]} = fa(a[3], b[3], c3);

endmodule

// File: rtl/csa16_ins.sv
// rtl/csa16_ins.sv - 16-bit registered carry-select adder; CSA16_OVF_EN adds the signed overflow output
module csa16_ins
    import csa16_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  csa_word_t a,
    input  csa_word_t b,
    input  logic      cin,
    output csa_word_t sum,
    output logic      cout
`ifdef CSA16_OVF_EN
    ,
    output logic      ovf
`endif
);

    csa_blk_t  s_blk0;
    logic      co_blk0;
    csa_blk_t  s_c0 [1:NUM_BLK-1];
    csa_blk_t  s_c1 [1:NUM_BLK-1];
    logic      co_c0 [1:NUM_BLK-1];
    logic      co_c1 [1:NUM_BLK-1];
    csa_word_t sum_c;
    logic      cout_c;

    for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
        if (k == 0) begin : g_base
            csa16_rca4 u_rca (
                .a  (a[BLK_W-1:0]),
                .b  (b[BLK_W-1:0]),
                .ci (cin),
                .s  (s_blk0),
                .co (co_blk0)
            );
        end else begin : g_pair
            // Both carry-in cases are resolved in parallel; only the select ripples.
            csa16_rca4 u_rca0 (
                .a  (a[k*BLK_W +: BLK_W]),
                .b  (b[k*BLK_W +: BLK_W]),
                .ci (1'b0),
                .s  (s_c0[k]),
                .co (co_c0[k])
            );
            csa16_rca4 u_rca1 (
                .a  (a[k*BLK_W +: BLK_W]),
                .b  (b[k*BLK_W +: BLK_W]),
                .ci (1'b1),
                .s  (s_c1[k]),
                .co (co_c1[k])
            );
        end
    end

    always_comb begin
        logic sel;
        sum_c             = '0;
        sum_c[BLK_W-1:0]  = s_blk0;
        sel               = co_blk0;
        for (int k = 1; k < NUM_BLK; k++) begin
            sum_c[k*BLK_W +: BLK_W] = sel ? s_c1[k] : s_c0[k];
            sel                     = sel ? co_c1[k] : co_c0[k];
        end
        cout_c = sel;
    end

`ifdef CSA16_OVF_EN
    logic ovf_c;
    // Carry into bit 15 is recovered from its sum bit rather than tapping the block-3 adder.
    assign ovf_c = (a[CSA_W-1] ^ b[CSA_W-1] ^ sum_c[CSA_W-1]) ^ cout_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
`ifdef CSA16_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            sum  <= sum_c;
            cout <= cout_c;
`ifdef CSA16_OVF_EN
            ovf  <= ovf_c;
`endif
        end
    end

endmodule

// File: tb/tb_csa16_ins.sv
// tb/tb_csa16_ins.sv - directed and back-to-back self-checking bench for csa16_ins
module tb_csa16_ins;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
`ifdef CSA16_OVF_EN
    logic        ovf;
`endif

    int n_vec;
    int n_fail;

    csa16_ins dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
`ifdef CSA16_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a     = 16'hFFFF;
        b     = 16'h0001;
        cin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (sum !== 16'h0000 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold sum=%h cout=%b expected sum=0000 cout=0", sum, cout);
        end
`ifdef CSA16_OVF_EN
        n_vec++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_ovf ovf=%b expected 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (sum !== 16'h0001 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release sum=%h cout=%b expected sum=0001 cout=1", sum, cout);
        end
    endtask

    task automatic test_directed;
        logic [15:0] va  [8] = '{16'd0, 16'd0, 16'd14, 16'd5, 16'd999, 16'hFFFF, 16'h0FFF, 16'hFFFF};
        logic [15:0] vb  [8] = '{16'd0, 16'd0, 16'd1,  16'd0, 16'd0,   16'h0000, 16'h0001, 16'hFFFF};
        logic        vc  [8] = '{1'b0,  1'b1,  1'b1,   1'b0,  1'b1,    1'b1,     1'b0,     1'b1};
        logic [15:0] vs  [8] = '{16'h0000, 16'h0001, 16'h0010, 16'h0005, 16'h03E8, 16'h0000, 16'h1000, 16'hFFFF};
        logic        vco [8] = '{1'b0,  1'b0,  1'b0,   1'b0,  1'b0,    1'b1,     1'b0,     1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(va[i], vb[i], vc[i]);
            n_vec++;
            if (sum !== vs[i] || cout !== vco[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] sum=%h cout=%b expected sum=%h cout=%b",
                         i, sum, cout, vs[i], vco[i]);
            end
        end
    endtask

    task automatic test_overflow;
        logic [15:0] va  [4] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};
        logic [15:0] vb  [4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
        logic        vc  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] vs  [4] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h7FFF};
        logic        vco [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        vov [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], vc[i]);
            n_vec++;
            if (sum !== vs[i] || cout !== vco[i]) begin
                n_fail++;
                $display("FAIL overflow[%0d] sum=%h cout=%b expected sum=%h cout=%b",
                         i, sum, cout, vs[i], vco[i]);
            end
`ifdef CSA16_OVF_EN
            n_vec++;
            if (ovf !== vov[i]) begin
                n_fail++;
                $display("FAIL overflow_flag[%0d] ovf=%b expected %b", i, ovf, vov[i]);
            end
`else
            if (vov[i] === 1'bx) $display("note: unexpected table entry %0d", i);
`endif
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] exp;
        for (int i = 0; i < 10000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            drive(ra, rb, rc);
            n_vec++;
            if ({cout, sum} !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b got cout=%b sum=%h expected cout=%b sum=%h",
                         i, ra, rb, rc, cout, sum, exp[16], exp[15:0]);
            end
`ifdef CSA16_OVF_EN
            n_vec++;
            if (ovf !== ((ra[15] == rb[15]) && (exp[15] != ra[15]))) begin
                n_fail++;
                $display("FAIL random_ovf[%0d] a=%h b=%h cin=%b ovf=%b", i, ra, rb, rc, ovf);
            end
`endif
            if (i == 5000) begin
                #2;
                rst_n = 1'b0;
                #1;
                n_vec++;
                if (sum !== 16'h0000 || cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL async_clear sum=%h cout=%b expected sum=0000 cout=0", sum, cout);
                end
                @(negedge clk);
                a   = 16'hFFFF;
                b   = 16'hFFFF;
                cin = 1'b1;
                @(posedge clk);
                #1;
                n_vec++;
                if (sum !== 16'h0000 || cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_midstream_hold sum=%h cout=%b expected sum=0000 cout=0", sum, cout);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        test_reset;
        test_directed;
        test_overflow;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
